// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// It recovers frames from the asynchronous 'uart' line and queues the good words.
// It pulses frame_err, parity_err and overrun when a frame or word is lost.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_10,
    input  logic                          reset_n,
    input  logic                          uart,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int IW   = 4;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic ODD_PARITY = (PARITY == 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_d, parity_err_d, push;

    logic sync1, s, s_d1, s_d2, bit_val;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr, count;
    logic                 full, pop, do_push;

    // Two-flop synchroniser followed by a two-deep history of s for majority voting
    always_ff @(posedge clk_10) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            s_d1  <= 1'b1;
            s_d2  <= 1'b1;
        end else begin
            sync1 <= uart;
            s     <= sync1;
            s_d1  <= s;
            s_d2  <= s_d1;
        end
    end

    assign bit_val = (s & s_d1) | (s & s_d2) | (s_d1 & s_d2);

    // Receiver state, bit-timing counter, bit index, shift register and error pulses
    always_ff @(posedge clk_10) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            frame_err  <= frame_err_d;
            parity_err <= parity_err_d;
        end
    end

    // Next-state logic: cnt holds the number of cycles since the last sample point
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (!s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!s) begin
                    cnt_d   = CW'(1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CW'(HALF)) begin
                    idx_d = '0;
                    if (bit_val) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT)) begin
                    cnt_d   = CW'(1);
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CW'(CLKS_PER_BIT)) begin
                    if ((^shift_q ^ bit_val) != ODD_PARITY) begin
                        parity_err_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = ST_WAIT_IDLE;
                    end else begin
                        cnt_d   = CW'(1);
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT)) begin
                    if (!bit_val) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        idx_d       = '0;
                        state_d     = ST_WAIT_IDLE;
                    end else if (idx_q == IW'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = CW'(1);
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == DEPTH_CNT);
    assign pop        = (count != '0) && rx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign do_push    = push && (!full || pop);

    assign fifo_count = count;
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // FIFO storage write port
    always_ff @(posedge clk_10) begin
        if (reset_n && do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift_q;
        end
    end

    // FIFO pointers (one bit wider than the address) and the overrun pulse
    always_ff @(posedge clk_10) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed sequences, a parity vector table and randomized frames.
// dut_a uses default parameters; dut_b uses even parity with 16 clocks per bit.
module tb_uart_rx_fifo;

    logic clk_10 = 1'b0;
    logic reset_n;
    logic uart_a, uart_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b, ovr_a, ovr_b;
    logic [2:0] cnt_a, cnt_b;

    uart_rx_fifo dut_a (
        .clk_10(clk_10), .reset_n(reset_n), .uart(uart_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .fifo_count(cnt_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(16), .PARITY(2)) dut_b (
        .clk_10(clk_10), .reset_n(reset_n), .uart(uart_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .fifo_count(cnt_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b)
    );

    always #5 clk_10 = ~clk_10;

    int cyc = 0;
    always @(posedge clk_10) cyc <= cyc + 1;

    // Monitors: record handshakes, error pulses and event times
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int ferr_na = 0, perr_na = 0, ovr_na = 0, ferr_nb = 0, perr_nb = 0, ovr_nb = 0;
    int rise_a = 0, ferr_cyc_a = 0, perr_cyc_b = 0;
    logic prev_valid_a = 1'b0;

    always @(negedge clk_10) begin
        if (valid_a && ready_a) got_a.push_back(data_a);
        if (ferr_a) begin ferr_na <= ferr_na + 1; ferr_cyc_a <= cyc; end
        if (perr_a) perr_na <= perr_na + 1;
        if (ovr_a) ovr_na <= ovr_na + 1;
        if (valid_a && !prev_valid_a) rise_a <= cyc;
        prev_valid_a <= valid_a;
    end

    always @(negedge clk_10) begin
        if (valid_b && ready_b) got_b.push_back(data_b);
        if (ferr_b) ferr_nb <= ferr_nb + 1;
        if (perr_b) begin perr_nb <= perr_nb + 1; perr_cyc_b <= cyc; end
        if (ovr_b) ovr_nb <= ovr_nb + 1;
    end

    int n_pass = 0, n_total = 0;
    int rd_a = 0, rd_b = 0;
    int base_fa = 0, base_pa = 0, base_oa = 0, base_fb = 0, base_pb = 0;
    int fall_a = 0, fall_b = 0;
    int occ, exp_o, exp_f;
    logic bad;
    logic [7:0] rnd;
    logic rand_ready = 1'b0;
    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] word;
        int         words;
        int         perr;
        int         ferr;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_10);
            #1;
            if (rand_ready) ready_a = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_line(input int d, input logic v);
        if (d == 0) uart_a = v;
        else uart_b = v;
    endtask

    // par < 0 means no parity bit is sent
    task automatic send_frame(input int d, input logic [7:0] data, input int par, input logic stop);
        int cpb;
        cpb = (d == 0) ? 87 : 16;
        set_line(d, 1'b0);
        if (d == 0) fall_a = cyc;
        else fall_b = cyc;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            set_line(d, data[i]);
            tick(cpb);
        end
        if (par >= 0) begin
            set_line(d, par[0]);
            tick(cpb);
        end
        set_line(d, stop);
        tick(cpb);
        set_line(d, 1'b1);
    endtask

    task automatic compare_a(input string name);
        check({name, " word count"}, got_a.size() - rd_a, model_q.size());
        for (int i = 0; i < model_q.size(); i++)
            if (rd_a + i < got_a.size())
                check($sformatf("%s word %0d", name, i), got_a[rd_a + i], model_q[i]);
        rd_a = got_a.size();
        model_q.delete();
    endtask

    task automatic errs_a(input string name, input int f, input int p, input int o);
        check({name, " frame_err pulses"}, ferr_na - base_fa, f);
        check({name, " parity_err pulses"}, perr_na - base_pa, p);
        check({name, " overrun pulses"}, ovr_na - base_oa, o);
        base_fa = ferr_na;
        base_pa = perr_na;
        base_oa = ovr_na;
    endtask

    initial begin
        vecs[0] = '{8'h07, 1'b1, 1'b1, 8'h07, 1, 0, 0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 8'h00, 0, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1, 0, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1, 0, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'h00, 0, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1, 0, 0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 8'h00, 0, 0, 1};
        vecs[7] = '{8'h55, 1'b1, 1'b0, 8'h00, 0, 1, 0};
        vecs[8] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1, 0, 0};
        vecs[9] = '{8'h01, 1'b0, 1'b1, 8'h00, 0, 1, 0};

        reset_n = 1'b0; uart_a = 1'b1; uart_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        tick(3);
        check("reset rx_valid", valid_a, 0);
        check("reset fifo_count", cnt_a, 0);
        check("reset rx_data", data_a, 0);
        check("reset flags", {ferr_a, perr_a, ovr_a}, 0);
        check("reset rx_valid b", valid_b, 0);
        reset_n = 1'b1;
        tick(100);

        // Back-to-back bytes with exact push latency
        send_frame(0, 8'h55, -1, 1'b1);
        check("b2b rx_valid latency", rise_a - fall_a, 829);
        model_q.push_back(8'h55);
        send_frame(0, 8'h3F, -1, 1'b1);
        model_q.push_back(8'h3F);
        tick(20);
        compare_a("b2b");
        errs_a("b2b", 0, 0, 0);

        // Glitch rejection
        uart_a = 1'b0; tick(20); uart_a = 1'b1;
        tick(150);
        check("glitch fifo_count", cnt_a, 0);
        compare_a("glitch");
        errs_a("glitch", 0, 0, 0);
        send_frame(0, 8'hA5, -1, 1'b1);
        model_q.push_back(8'hA5);
        tick(20);
        compare_a("post-glitch");

        // Framing error followed by a long low line
        send_frame(0, 8'hA5, -1, 1'b0);
        check("frame_err latency", ferr_cyc_a - fall_a, 829);
        uart_a = 1'b0; tick(174); uart_a = 1'b1;
        tick(100);
        check("frame_err fifo_count", cnt_a, 0);
        compare_a("frame_err");
        errs_a("frame_err", 1, 0, 0);
        send_frame(0, 8'h12, -1, 1'b1);
        model_q.push_back(8'h12);
        tick(20);
        compare_a("post-frame_err");
        errs_a("post-frame_err", 0, 0, 0);

        // Even parity on dut_b: bad then good parity bit
        send_frame(1, 8'h07, 0, 1'b1);
        check("parity_err latency", perr_cyc_b - fall_b, 155);
        tick(40);
        check("parity bad pulses", perr_nb - base_pb, 1);
        check("parity bad words", got_b.size() - rd_b, 0);
        base_pb = perr_nb; rd_b = got_b.size();
        send_frame(1, 8'h07, 1, 1'b1);
        tick(10);
        check("parity good words", got_b.size() - rd_b, 1);
        if (got_b.size() > rd_b) check("parity good word", got_b[rd_b], 8'h07);
        check("parity good pulses", perr_nb - base_pb, 0);
        rd_b = got_b.size();

        // Parity/framing vector table on dut_b
        for (int i = 0; i < 10; i++) begin
            send_frame(1, vecs[i].data, int'(vecs[i].par), vecs[i].stop);
            tick(40);
            check($sformatf("vec%0d words", i), got_b.size() - rd_b, vecs[i].words);
            if (vecs[i].words == 1 && got_b.size() > rd_b)
                check($sformatf("vec%0d word", i), got_b[rd_b], vecs[i].word);
            check($sformatf("vec%0d parity_err", i), perr_nb - base_pb, vecs[i].perr);
            check($sformatf("vec%0d frame_err", i), ferr_nb - base_fb, vecs[i].ferr);
            base_pb = perr_nb; base_fb = ferr_nb; rd_b = got_b.size();
        end

        // Overrun and ordering with a capacity-4 queue model
        ready_a = 1'b0; occ = 0; exp_o = 0;
        for (int w = 1; w <= 5; w++) begin
            send_frame(0, 8'(w), -1, 1'b1);
            if (occ < 4) begin model_q.push_back(8'(w)); occ++; end
            else exp_o++;
        end
        tick(20);
        check("overrun fifo_count", cnt_a, occ);
        errs_a("overrun", 0, 0, exp_o);
        ready_a = 1'b1;
        tick(10);
        compare_a("drain");
        check("drain rx_valid", valid_a, 0);

        // Reset during data bit 3 with two words queued
        ready_a = 1'b0;
        send_frame(0, 8'h21, -1, 1'b1);
        send_frame(0, 8'h42, -1, 1'b1);
        tick(5);
        check("pre-reset fifo_count", cnt_a, 2);
        fork
            send_frame(0, 8'h08, -1, 1'b1);
            begin
                repeat (390) @(posedge clk_10);
                #1 reset_n = 1'b0;
                @(posedge clk_10);
                #1;
                check("midreset rx_valid", valid_a, 0);
                check("midreset fifo_count", cnt_a, 0);
                check("midreset rx_data", data_a, 0);
                check("midreset flags", {ferr_a, perr_a, ovr_a}, 0);
                reset_n = 1'b1;
            end
        join
        tick(120);
        ready_a = 1'b1;
        tick(5);
        compare_a("after reset");
        errs_a("after reset", 0, 0, 0);
        send_frame(0, 8'hC3, -1, 1'b1);
        model_q.push_back(8'hC3);
        tick(20);
        compare_a("post-reset frame");

        // Randomized frames and consumer stalls
        rand_ready = 1'b1; exp_f = 0;
        repeat (16) begin
            rnd = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(0, rnd, -1, !bad);
            if (bad) begin
                exp_f++;
                tick(120);
            end else begin
                model_q.push_back(rnd);
                tick($urandom_range(0, 15));
            end
        end
        tick(100);
        rand_ready = 1'b0; ready_a = 1'b1;
        tick(10);
        compare_a("random");
        errs_a("random", exp_f, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with on-chip receive FIFO, the next-generation serial input for the `top` design: it accepts the asynchronous `uart` line, recovers frames with configurable data width, parity and stop bits, and presents received words on a first-word-fall-through valid/ready interface. It also reports framing, parity and overrun errors, which the current receive path does not. It sits directly behind the `uart` pin, and its consumer is the command/LED logic clocked by `clk_10`.

## Interface
- `CLKS_PER_BIT`, 87: `clk_10` cycles per bit (at least 8).
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: words, power of two, at least 2.
- `clk_10` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `uart` in 1: asynchronous serial line, idle high.
- `rx_data` out `DATA_BITS`: FIFO head word, valid only while `rx_valid` is high.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts the head word when `rx_valid && rx_ready`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: words currently stored.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled 0.
- `parity_err` out 1: one-cycle pulse when the parity bit mismatches.
- `overrun` out 1: one-cycle pulse when a good word is dropped because the FIFO is full.

## Operation
- **Synchroniser:** `uart` passes through two flops, giving `s`. Both flops reset to 1.
- **Sampling:** a bit value is the majority of `s` over the sample cycle and the two cycles before it.
- **States:** WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
- **WAIT_IDLE** (reset state, also entered after any error):
  - Count consecutive cycles with `s`=1; any 0 clears the count.
  - After `CLKS_PER_BIT` consecutive cycles go to IDLE.
- **IDLE:** the first cycle with `s`=0 is cycle E. Go to START.
- **Bit sample points:** bit i (i=0 is the start bit) is sampled at cycle E + CLKS_PER_BIT/2 + i*CLKS_PER_BIT, integer division.
- **START:** sample bit 0. If 1, it is a false start: return to IDLE with no flag.
- **DATA:** shift in `DATA_BITS` samples, LSB first.
- **PARITY** (only when `PARITY`≠0):
  - Odd: the count of ones over data plus parity must be odd. Even: it must be even.
  - On mismatch, pulse `parity_err`, drop the word and go to WAIT_IDLE.
- **STOP:** sample `STOP_BITS` stop bits.
  - If any is 0, pulse `frame_err`, drop the word and go to WAIT_IDLE.
  - Both flags are checked at their own sample cycle, and at most one error flag fires per frame.
- **Frame complete:** on the last good stop sample, push the word and go to IDLE.
  - IDLE can detect a new start from the next cycle onward.
- **FIFO:**
  - Circular buffer of `FIFO_DEPTH` entries. Read and write pointers are one bit wider than the address and wrap modulo 2×depth.
  - A push while full is dropped and pulses `overrun`; the contents are unchanged.
  - A push and a pop in the same cycle are both performed and `fifo_count` is unchanged. This also holds when full: the pop frees space, so the push succeeds with no overrun.
  - A pop while empty is ignored.
- **Reset:** `reset_n`=0 at any point, including mid-frame, applies the following in the same clock edge:
  - The FIFO is emptied.
  - `rx_valid`, `frame_err`, `parity_err` and `overrun` are 0, and `fifo_count` is 0.
  - `rx_data` is 0 (the head of the empty FIFO reads 0).
  - The state is WAIT_IDLE and all counters are 0.

## Timing
- Synchroniser latency is 2 cycles: if `uart` falls before edge T0, then E = T0+2.
- The push occurs at the last stop sample cycle P. `rx_valid` is high and `fifo_count` is incremented from cycle P+1; both are registered.
- With default parameters, P = E + 43 + 9×87 = E + 826.
- The FIFO adds zero extra latency: the head word appears on `rx_data` in the same cycle `rx_valid` rises.
- A pop at edge k updates `rx_data`, `rx_valid` and `fifo_count` from cycle k+1.
- Error pulses are high for exactly the one cycle after the offending sample.
- All outputs are registered; there is no combinational path from `uart` or `rx_ready` to any output.

## Test plan
1. **Back-to-back bytes.** Defaults, 10 ns clock, 870 ns bits, `rx_ready`=1. Send 0x55 then 0x3F, each with start bit and one stop bit, back to back. Required: two `rx_valid` handshakes with `rx_data` = 0x55 then 0x3F, and no error pulses.
2. **Glitch rejection.** Pulse `uart` low for 200 ns (20 cycles) while idle. Required: no word, no error, and `fifo_count` stays 0. A following valid 0xA5 frame is received correctly.
3. **Framing error.** Send 0xA5 with the stop bit driven 0, then hold the line low for 2 bit times, then release it. Required: one `frame_err` pulse, `fifo_count` stays 0, and no frame starts while the line is low. After ≥870 ns high, a 0x12 frame is received.
4. **Parity.** `PARITY`=2. Send 0x07 with parity bit 0. Required: one `parity_err` pulse and no word. Then send 0x07 with parity bit 1. Required: `rx_data`=0x07 and no error.
5. **Overrun and ordering.** `FIFO_DEPTH`=4, `rx_ready`=0. Send 0x01..0x05. Required: `fifo_count`=4 and one `overrun` pulse on the 5th frame. Then raise `rx_ready`. Required: words pop as 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
6. **Reset mid-frame.** Assert `reset_n`=0 for one cycle during data bit 3 of a frame, with 2 words already queued. Required: all outputs are 0 at the next cycle, the rest of the interrupted frame produces nothing, and a frame sent after 870 ns of idle line is received correctly.
